interrupt_sequencer: RTL

Arbitrates RESET, NMI and IRQ requests for the CPU control logic and sequences interrupt entry through the timing state machine. Sits between the instruction decoder and the state machine on the instruction/addressing-mode path. At each instruction boundary it either passes the decoded instruction through or substitutes the forced interrupt instruction. During the forced sequence it supplies the vector select and write-suppression controls to the datapath.

---
 rtl/interrupt_sequencer_if.sv | 41 ++++
 rtl/interrupt_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_sequencer_if
//  Description : Request, decoder and control bundle between the CPU control
//                logic and the interrupt sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface interrupt_sequencer_if;
    logic       resetReq;
    logic       nmiReq;
    logic       irqReq;
    logic       iFlag;
    logic       getInstruction;
    logic [5:0] decodedInstruction;
    logic [3:0] decodedAddress;
    logic [5:0] instructionOut;
    logic [3:0] addressOut;
    logic       interruptActive;
    logic [1:0] vectorSel;
    logic       suppressWrite;
    logic       nmiAck;
    logic [2:0] cycleCount;
    logic       serviceError;

    // Control logic side: raises requests, consumes the sequenced outputs
    modport master (
        output resetReq, nmiReq, irqReq, iFlag, getInstruction,
        output decodedInstruction, decodedAddress,
        input  instructionOut, addressOut, interruptActive, vectorSel,
        input  suppressWrite, nmiAck, cycleCount, serviceError
    );

    // Sequencer side
    modport slave (
        input  resetReq, nmiReq, irqReq, iFlag, getInstruction,
        input  decodedInstruction, decodedAddress,
        output instructionOut, addressOut, interruptActive, vectorSel,
        output suppressWrite, nmiAck, cycleCount, serviceError
    );
endinterface
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_sequencer
//  Description : Arbitrates RESET/NMI/IRQ, substitutes the forced interrupt
//                instruction at instruction boundaries and drives vector
//                select / write suppression during interrupt entry.
//  Revision    : 1.0  initial release
// ============================================================================
module interrupt_sequencer #(
    parameter logic [5:0] INT_INSTR  = 6'd56,
    parameter logic [3:0] INT_ADDR   = 4'd0,
    parameter int         MAX_CYCLES = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    interrupt_sequencer_if.slave bus
);

    localparam int WD_W = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_SERVICE = 1'b1;

    // Source encoding doubles as the vector select encoding
    localparam logic [1:0] SRC_NONE  = 2'b00;
    localparam logic [1:0] SRC_NMI   = 2'b01;
    localparam logic [1:0] SRC_RESET = 2'b10;
    localparam logic [1:0] SRC_IRQ   = 2'b11;

    localparam logic [2:0] CNT_SAT   = 3'd7;

    logic [0:0]      state_q,         state_d;
    logic [1:0]      src_q,           src_d;
    logic            reset_pending_q, reset_pending_d;
    logic            nmi_pending_q,   nmi_pending_d;
    logic            nmi_prev_q,      nmi_prev_d;
    logic            nmi_ack_q,       nmi_ack_d;
    logic [2:0]      cycle_count_q,   cycle_count_d;
    logic [WD_W-1:0] wd_count_q,      wd_count_d;
    logic            service_error_q, service_error_d;

    logic            w_irq_eligible;
    logic            w_nmi_edge;
    logic            w_source_present;
    logic [1:0]      w_win_src;
    logic            w_accept;
    logic [WD_W-1:0] w_wd_next;

    // Arbitration: current sources and the winner by RESET > NMI > IRQ
    always_comb begin
        w_irq_eligible   = bus.irqReq & ~bus.iFlag;
        w_nmi_edge       = bus.nmiReq & ~nmi_prev_q;
        w_source_present = reset_pending_q | nmi_pending_q | w_irq_eligible;
        if (reset_pending_q) begin
            w_win_src = SRC_RESET;
        end else if (nmi_pending_q) begin
            w_win_src = SRC_NMI;
        end else if (w_irq_eligible) begin
            w_win_src = SRC_IRQ;
        end else begin
            w_win_src = SRC_NONE;
        end
        w_accept  = bus.getInstruction & w_source_present;
        w_wd_next = wd_count_q + 1'b1;
    end

    // Pending-source bookkeeping; a fresh NMI edge beats a same-cycle clear
    always_comb begin
        reset_pending_d = bus.resetReq
                        | (reset_pending_q & ~(w_accept && (w_win_src == SRC_RESET)));
        nmi_pending_d   = w_nmi_edge
                        | (nmi_pending_q & ~(w_accept && (w_win_src == SRC_NMI)));
        nmi_ack_d       = w_accept && (w_win_src == SRC_NMI);
        nmi_prev_d      = bus.nmiReq;
    end

    // Next-state logic: entry, back-to-back relatch, exit and watchdog
    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        cycle_count_d   = cycle_count_q;
        wd_count_d      = wd_count_q;
        service_error_d = service_error_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d       = S_SERVICE;
                    src_d         = w_win_src;
                    cycle_count_d = 3'd0;
                    wd_count_d    = '0;
                end
            end
            S_SERVICE: begin
                if (bus.getInstruction) begin
                    if (w_source_present) begin
                        // Forced instruction ended with another source waiting
                        state_d       = S_SERVICE;
                        src_d         = w_win_src;
                        cycle_count_d = 3'd0;
                        wd_count_d    = '0;
                    end else begin
                        state_d       = S_IDLE;
                        src_d         = SRC_NONE;
                        cycle_count_d = 3'd0;
                        wd_count_d    = '0;
                    end
                end else if (w_wd_next >= WD_W'(MAX_CYCLES)) begin
                    // Sequence never reached its boundary: abandon it
                    service_error_d = 1'b1;
                    state_d         = S_IDLE;
                    src_d           = SRC_NONE;
                    cycle_count_d   = 3'd0;
                    wd_count_d      = '0;
                end else begin
                    wd_count_d = w_wd_next;
                    if (cycle_count_q != CNT_SAT) begin
                        cycle_count_d = cycle_count_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d       = S_IDLE;
                src_d         = SRC_NONE;
                cycle_count_d = 3'd0;
                wd_count_d    = '0;
            end
        endcase
    end

    // State register; reset arms a RESET sequence and ignores a held NMI line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            src_q           <= SRC_NONE;
            reset_pending_q <= 1'b1;
            nmi_pending_q   <= 1'b0;
            nmi_prev_q      <= 1'b1;
            nmi_ack_q       <= 1'b0;
            cycle_count_q   <= 3'd0;
            wd_count_q      <= '0;
            service_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            src_q           <= src_d;
            reset_pending_q <= reset_pending_d;
            nmi_pending_q   <= nmi_pending_d;
            nmi_prev_q      <= nmi_prev_d;
            nmi_ack_q       <= nmi_ack_d;
            cycle_count_q   <= cycle_count_d;
            wd_count_q      <= wd_count_d;
            service_error_q <= service_error_d;
        end
    end

    // Outputs: zero-latency substitution plus flop-derived status
    always_comb begin
        if (w_accept) begin
            bus.instructionOut = INT_INSTR;
            bus.addressOut     = INT_ADDR;
        end else begin
            bus.instructionOut = bus.decodedInstruction;
            bus.addressOut     = bus.decodedAddress;
        end
        bus.interruptActive = (state_q == S_SERVICE);
        bus.vectorSel       = (state_q == S_SERVICE) ? src_q : SRC_NONE;
        bus.suppressWrite   = (state_q == S_SERVICE) && (src_q == SRC_RESET);
        bus.nmiAck          = nmi_ack_q;
        bus.cycleCount      = cycle_count_q;
        bus.serviceError    = service_error_q;
    end

endmodule
`default_nettype wire
